// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous word memory between the fetch and
// load/store requesters of the mini-MIPS core.
//
// Arbitration policy:
//   Data requests normally win over fetch. A streak counter limits this.
//   After MAX_D_STREAK consecutive data grants made while fetch was waiting,
//   the next grant goes to fetch.
//
// Access sequence:
//   Each access runs IDLE -> ISSUE -> (WAIT) -> RESP.
//   The winning requester gets a one-cycle ready pulse in RESP.
//
// Optional statistics counters:
//   Define MEM_ARB_STATS_EN to build them.
//   Without it, the stat_* ports are tied to 0.
//
// Parameters:
//   ADDR_W        word-address width of the memory (2**ADDR_W words)
//   LATENCY       cycles from the mem_en cycle to valid mem_rdata (1..7)
//   MAX_D_STREAK  consecutive data grants allowed while fetch waits
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   if_req/if_addr      fetch request and byte address
//   if_rdata/if_ready   fetched word and its completion pulse
//   d_req/d_we/d_addr/d_wdata  data request, store flag, byte address, store data
//   d_rdata/d_ready/d_err      load data, completion pulse, misaligned flag
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory port
//   stat_if_grants/stat_d_grants/stat_if_stall   optional statistics
module mem_port_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int LATENCY      = 1,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ready,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [15:0]       stat_if_grants,
  output logic [15:0]       stat_d_grants,
  output logic [15:0]       stat_if_stall
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam int STREAK_W = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  localparam logic [2:0] WAIT_LOAD = 3'(LATENCY);

  logic [1:0]          state;
  logic                sel_d;
  logic                sel_we;
  logic                sel_err;
  logic [2:0]          wait_cnt;
  logic [STREAK_W-1:0] streak;
  logic                pick_d;
  logic                pick_if;
  logic                d_misaligned;

  // Byte-offset bits of the fetch address and the address bits above the
  // memory are not needed by the arbiter.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0], d_addr[31:ADDR_W+2]};

  // Data wins unless fetch is waiting and data has used up its streak
  // allowance. These selects are only acted on in IDLE.
  always_comb begin
    d_misaligned = (d_addr[1:0] != 2'b00);
    pick_d       = d_req && !(if_req && (streak == STREAK_MAX));
    pick_if      = if_req && !pick_d;
  end

  // Main sequencer.
  // Every output is a register, so each strobe is set on the transition
  // into the cycle where it must be visible.
  //
  // Misaligned data requests still pass through ISSUE. In ISSUE, mem_en is
  // held low for them. This gives them the same two-cycle response as a
  // store, without touching memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      sel_d     <= 1'b0;
      sel_we    <= 1'b0;
      sel_err   <= 1'b0;
      wait_cnt  <= 3'd0;
      streak    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      if_ready  <= 1'b0;
      if_rdata  <= 32'd0;
      d_ready   <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= 32'd0;
    end else begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      d_err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_d) begin
            sel_d   <= 1'b1;
            sel_we  <= d_we;
            sel_err <= d_misaligned;
            state   <= ST_ISSUE;
            if (!d_misaligned) begin
              mem_en    <= 1'b1;
              mem_we    <= d_we;
              mem_addr  <= d_addr[ADDR_W+1:2];
              mem_wdata <= d_wdata;
            end
            if (if_req) begin
              if (streak != STREAK_MAX) begin
                streak <= streak + 1'b1;
              end
            end else begin
              streak <= '0;
            end
          end else if (pick_if) begin
            sel_d    <= 1'b0;
            sel_we   <= 1'b0;
            sel_err  <= 1'b0;
            state    <= ST_ISSUE;
            mem_en   <= 1'b1;
            mem_addr <= if_addr[ADDR_W+1:2];
            streak   <= '0;
          end
        end
        ST_ISSUE: begin
          if (sel_err) begin
            d_ready <= 1'b1;
            d_err   <= 1'b1;
            d_rdata <= 32'd0;
            state   <= ST_RESP;
          end else if (sel_we) begin
            d_ready <= 1'b1;
            state   <= ST_RESP;
          end else begin
            wait_cnt <= WAIT_LOAD;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          // A count of 1 marks the cycle LATENCY cycles after ISSUE.
          if (wait_cnt == 3'd1) begin
            if (sel_d) begin
              d_rdata <= mem_rdata;
              d_ready <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_ready <= 1'b1;
            end
            state <= ST_RESP;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic grant_d;
  logic grant_if;
  assign grant_d  = (state == ST_IDLE) && pick_d;
  assign grant_if = (state == ST_IDLE) && pick_if;

  // Saturating statistics counters.
  // A stall is any cycle where fetch is requesting and not being answered.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_if_grants <= 16'd0;
      stat_d_grants  <= 16'd0;
      stat_if_stall  <= 16'd0;
    end else begin
      if (grant_if && (stat_if_grants != 16'hFFFF)) begin
        stat_if_grants <= stat_if_grants + 16'd1;
      end
      if (grant_d && (stat_d_grants != 16'hFFFF)) begin
        stat_d_grants <= stat_d_grants + 16'd1;
      end
      if (if_req && !if_ready && (stat_if_stall != 16'hFFFF)) begin
        stat_if_stall <= stat_if_stall + 16'd1;
      end
    end
  end
`else
  assign stat_if_grants = 16'd0;
  assign stat_d_grants  = 16'd0;
  assign stat_if_stall  = 16'd0;
`endif

endmodule
